// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Full shadow entry; the EX stage needs every field for hazard detection
  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              ld;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } stage_t;

  // MEM/WB entries only feed forwarding, so only the write port survives
  typedef struct packed {
    logic              rw;
    logic [REG_AW-1:0] dest;
  } wr_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones.
module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline, driven
// from a shadow copy of the EX/MEM/WB register-write state.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W  = REG_AW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_jump,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_t ex_p0_q,  ex_p0_d;
  wr_t    mem_p1_q, mem_p1_d;
  wr_t    wb_p2_q,  wb_p2_d;
  logic   lu;
  logic   stall_inc;
  logic   flush_inc;

  // MEM wins over WB because it carries the younger result; $0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input wr_t m_s, input wr_t w_s);
    if (m_s.rw && (m_s.dest != '0) && (m_s.dest == src)) return FWD_MEM;
    if (w_s.rw && (w_s.dest != '0) && (w_s.dest == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    lu = ex_p0_q.valid && ex_p0_q.ld && ex_p0_q.rw && (ex_p0_q.dest != '0) && id_valid &&
         ((id_use_rs && (id_rs == ex_p0_q.dest)) || (id_use_rt && (id_rt == ex_p0_q.dest)));
  end

  // Priority: reset, memory stall, taken branch, load-use, jump
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst_n) begin
      if (ext_stall) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
      end else if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign fwd_a = fwd_sel(ex_p0_q.rs, mem_p1_q, wb_p2_q);
  assign fwd_b = fwd_sel(ex_p0_q.rt, mem_p1_q, wb_p2_q);

  always_comb begin
    ex_p0_d  = ex_p0_q;
    mem_p1_d = mem_p1_q;
    wb_p2_d  = wb_p2_q;
    if (!ext_stall) begin
      wb_p2_d       = mem_p1_q;
      mem_p1_d.rw   = ex_p0_q.rw;
      mem_p1_d.dest = ex_p0_q.dest;
      if (idex_flush) begin
        ex_p0_d = '0;
      end else begin
        ex_p0_d.valid = id_valid;
        ex_p0_d.rw    = id_reg_write;
        ex_p0_d.ld    = id_mem_to_reg;
        ex_p0_d.dest  = id_dest;
        ex_p0_d.rs    = id_rs;
        ex_p0_d.rt    = id_rt;
      end
    end
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p0_q  <= '0;
      mem_p1_q <= '0;
      wb_p2_q  <= '0;
    end else begin
      ex_p0_q  <= ex_p0_d;
      mem_p1_q <= mem_p1_d;
      wb_p2_q  <= wb_p2_d;
    end
  end

  assign stall_inc = !ext_stall && lu && !ex_br_taken;
  assign flush_inc = !ext_stall && ifid_flush;

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_inc),
    .cnt   (stall_cnt)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle expectations queued with the
// stimulus and compared at the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_stall, id_valid, id_use_rs, id_use_rt;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_reg_write, id_mem_to_reg, id_jump, ex_br_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] es = '0;
  logic [15:0] ef = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ext_stall     (ext_stall),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_dest       (id_dest),
    .id_reg_write  (id_reg_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_jump       (id_jump),
    .ex_br_taken   (ex_br_taken),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] d,
                        input logic rw, input logic ld, input logic j);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_reg_write = rw; id_mem_to_reg = ld; id_jump = j;
  endtask

  task automatic id_nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic id_r(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    set_id(1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic id_lw(input logic [4:0] d, input logic [4:0] base);
    set_id(1'b1, base, d, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic id_j();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v, input bit inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush}; inputs already applied
  task automatic cyc(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input bit inc_s, input bit inc_f, input string tag);
    exp_t e;
    e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = es; e.fc = ef;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_val({tag, ".ctl"},   {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, e.ctl});
    check_val({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
    check_val({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
    check_val({tag, ".stall"}, {16'd0, stall_cnt}, {16'd0, e.sc});
    check_val({tag, ".flush"}, {16'd0, flush_cnt}, {16'd0, e.fc});
    es = sat16(es, inc_s);
    ef = sat16(ef, inc_f);
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    id_nop();
    for (int i = 0; i < n; i++) cyc(4'b1100, 2'b00, 2'b00, 0, 0, "nop");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ext_stall = 1'b1; ex_br_taken = 1'b1; id_j();
    @(posedge clk); #1;
    cyc(4'b1100, 2'b00, 2'b00, 0, 0, "rst");
    rst_n = 1'b1; ext_stall = 1'b0; ex_br_taken = 1'b0;
    nops(2);

    // add $3,$1,$2 ; sub $4,$3,$1 ; and $3,$3,$3
    id_r(5'd3, 5'd1, 5'd2); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "add");
    id_r(5'd4, 5'd3, 5'd1); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "sub_id");
    id_r(5'd3, 5'd3, 5'd3); cyc(4'b1100, 2'b10, 2'b00, 0, 0, "sub_ex");
    id_nop();               cyc(4'b1100, 2'b01, 2'b01, 0, 0, "and_ex");
    nops(3);

    // Both MEM and WB write $3: MEM must win
    id_r(5'd3, 5'd1, 5'd1); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "pri0");
    id_r(5'd3, 5'd2, 5'd2); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "pri1");
    id_r(5'd8, 5'd3, 5'd3); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "pri2");
    id_nop();               cyc(4'b1100, 2'b10, 2'b10, 0, 0, "pri_ex");
    nops(3);

    // lw $2,0($1) ; add $5,$2,$2
    id_lw(5'd2, 5'd1);      cyc(4'b1100, 2'b00, 2'b00, 0, 0, "lw");
    id_r(5'd5, 5'd2, 5'd2); cyc(4'b0001, 2'b00, 2'b00, 1, 0, "lu");
                            cyc(4'b1100, 2'b00, 2'b00, 0, 0, "lu_hold");
    id_nop();               cyc(4'b1100, 2'b01, 2'b01, 0, 0, "lu_fwd");
    nops(3);

    // Taken branch over a pending load-use
    id_lw(5'd2, 5'd1);      cyc(4'b1100, 2'b00, 2'b00, 0, 0, "br_lw");
    id_r(5'd5, 5'd2, 5'd2); ex_br_taken = 1'b1;
                            cyc(4'b1111, 2'b00, 2'b00, 0, 1, "br");
    ex_br_taken = 1'b0; id_nop();
                            cyc(4'b1100, 2'b00, 2'b00, 0, 0, "br_after");
    nops(2);

    id_j();                 cyc(4'b1110, 2'b00, 2'b00, 0, 1, "jmp");
    nops(2);

    // add $0,$1,$1 ; or $6,$0,$0
    id_r(5'd0, 5'd1, 5'd1); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "r0_add");
    id_r(5'd6, 5'd0, 5'd0); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "r0_or_id");
    id_nop();               cyc(4'b1100, 2'b00, 2'b00, 0, 0, "r0_or_ex");
    nops(2);

    // ext_stall held over a pending load-use (with a branch during the hold)
    id_lw(5'd2, 5'd1);      cyc(4'b1100, 2'b00, 2'b00, 0, 0, "xs_lw");
    id_r(5'd5, 5'd2, 5'd2); ext_stall = 1'b1;
                            cyc(4'b0000, 2'b00, 2'b00, 0, 0, "xs0");
    ex_br_taken = 1'b1;     cyc(4'b0000, 2'b00, 2'b00, 0, 0, "xs1");
    ex_br_taken = 1'b0;     cyc(4'b0000, 2'b00, 2'b00, 0, 0, "xs2");
    ext_stall = 1'b0;       cyc(4'b0001, 2'b00, 2'b00, 1, 0, "xs_lu");
                            cyc(4'b1100, 2'b00, 2'b00, 0, 0, "xs_hold");
    id_nop();               cyc(4'b1100, 2'b01, 2'b01, 0, 0, "xs_fwd");
    nops(2);

    // Reset pulled between edges with live state and nonzero counters
    id_r(5'd3, 5'd1, 5'd2); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "mr_add");
    id_r(5'd4, 5'd3, 5'd1); cyc(4'b1100, 2'b00, 2'b00, 0, 0, "mr_sub");
    id_r(5'd3, 5'd3, 5'd3); ext_stall = 1'b1;
    check_val("mr_pre.fwd_a", {30'd0, fwd_a}, 32'd2);
    #2;
    rst_n = 1'b0; es = '0; ef = '0;
    cyc(4'b1100, 2'b00, 2'b00, 0, 0, "mr_rst");
    rst_n = 1'b1; ext_stall = 1'b0;
    cyc(4'b1100, 2'b00, 2'b00, 0, 0, "mr_id");
    id_nop();
    cyc(4'b1100, 2'b00, 2'b00, 0, 0, "mr_ex");

    // Flush counter saturation
    id_j();
    repeat (65538) begin
      @(posedge clk); #1;
      ef = sat16(ef, 1);
    end
    cyc(4'b1110, 2'b00, 2'b00, 0, 1, "sat0");
    cyc(4'b1110, 2'b00, 2'b00, 0, 1, "sat1");
    check_val("sat_final", {16'd0, flush_cnt}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
